// File: rtl/sync_counter_pkg.sv
// Shared types and step function for the parametrised counter.
// Arithmetic is done at a fixed 33 bits so any WIDTH up to 32 fits.
package sync_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef struct packed {
    logic        wrap;
    logic [32:0] value;
  } step_t;

  function automatic step_t next_count(
    input logic [32:0] cnt,
    input logic        dir,
    input logic [32:0] modulus
  );
    step_t r;
    r.wrap  = 1'b0;
    r.value = cnt;
    if (dir == DIR_UP) begin
      if (cnt == modulus - 33'd1) begin
        r.value = '0;
        r.wrap  = 1'b1;
      end else begin
        r.value = cnt + 33'd1;
      end
    end else begin
      if (cnt == '0) begin
        r.value = modulus - 33'd1;
        r.wrap  = 1'b1;
      end else begin
        r.value = cnt - 33'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_counter_tc.sv
// Terminal-count and ripple-carry decode, shared by every cascade stage.
// tc depends on ent only; rco additionally needs enp.
module sync_counter_tc
  import sync_counter_pkg::*;
#(
  parameter int     WIDTH   = 4,
  parameter longint MODULUS = 16
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic             dir,
  input  logic             ent,
  input  logic             enp,
  output logic             tc,
  output logic             rco
);

  localparam logic [32:0] TOP_X = 33'(MODULUS) - 33'd1;

  logic [WIDTH-1:0] tv;

  assign tv  = (dir == DIR_UP) ? TOP_X[WIDTH-1:0] : '0;
  assign tc  = ent & (cnt == tv);
  assign rco = tc & enp;

endmodule

// File: rtl/sync_counter_param.sv
// Parametrised up/down modulo counter with clamped load,
// optional one-shot stop and registered wrap/load_err pulses.
module sync_counter_param
  import sync_counter_pkg::*;
#(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 16,
  parameter int     ONE_SHOT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_n,
  input  logic             load_n,
  input  logic [WIDTH-1:0] d,
  input  logic             enp,
  input  logic             ent,
  input  logic             dir,
  input  logic             oe,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             rco,
  output logic             wrap,
  output logic             done,
  output logic             load_err
);

  localparam logic [32:0] MOD_X = 33'(MODULUS);
  localparam logic [32:0] TOP_X = MOD_X - 33'd1;
  localparam logic        OS    = (ONE_SHOT != 0);

  logic [WIDTH-1:0] cnt;
  logic             wrap_q;
  logic             done_q;
  logic             lerr_q;
  logic             tc_i;
  logic             rco_i;
  logic             clamp;
  logic [WIDTH-1:0] load_v;
  logic             step_en;
  step_t            nxt;
  logic             unused_hi;

  assign clamp   = (33'(d) >= MOD_X);
  assign load_v  = clamp ? TOP_X[WIDTH-1:0] : d;
  assign step_en = enp & ent & ~(OS & done_q);
  assign nxt     = next_count(33'(cnt), dir, MOD_X);
  assign unused_hi = ^nxt.value[32:WIDTH];

  sync_counter_tc #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_tc (
    .cnt (cnt),
    .dir (dir),
    .ent (ent),
    .enp (enp),
    .tc  (tc_i),
    .rco (rco_i)
  );

  // Count register with clear > load > step > hold priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
      lerr_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      lerr_q <= 1'b0;
      if (!clr_n) begin
        cnt    <= '0;
        done_q <= 1'b0;
      end else if (!load_n) begin
        cnt    <= load_v;
        lerr_q <= clamp;
        done_q <= 1'b0;
      end else if (step_en) begin
        if (OS && tc_i) begin
          done_q <= 1'b1;
        end else begin
          cnt    <= nxt.value[WIDTH-1:0];
          wrap_q <= nxt.wrap;
        end
      end
    end
  end

  assign q        = oe ? cnt : '0;
  assign tc       = tc_i;
  assign rco      = rco_i;
  assign wrap     = wrap_q;
  assign done     = done_q;
  assign load_err = lerr_q;

endmodule

// File: tb/tb_sync_counter_param.sv
// Self-checking bench: decade counter, one-shot variant and 8-bit cascade
// compared against a modulo-arithmetic reference model.
module tb_sync_counter_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, clr_n, load_n, enp, ent, dir, oe;
  logic [3:0] d;
  logic [3:0] q0, q1;
  logic       tc0, tc1, rco0, rco1, wrap0, wrap1;
  logic       done0, done1, le0, le1;

  logic       c_clr_n, c_load_n, c_en, c_dir, c_oe;
  logic [3:0] c_dlo, c_dhi, lo_q, hi_q;
  logic       lo_tc, lo_rco, hi_tc, hi_rco;
  logic       lo_wrap, hi_wrap, lo_done, hi_done, lo_le, hi_le;

  int total = 0;
  int bad   = 0;

  int m_cnt  [2];
  bit m_wrap [2];
  bit m_le   [2];
  bit m_done [2];
  int cv;

  sync_counter_param #(.WIDTH(4), .MODULUS(10), .ONE_SHOT(0)) dut (
    .clk(clk), .rst_n(rst_n), .clr_n(clr_n), .load_n(load_n), .d(d),
    .enp(enp), .ent(ent), .dir(dir), .oe(oe), .q(q0), .tc(tc0),
    .rco(rco0), .wrap(wrap0), .done(done0), .load_err(le0)
  );

  sync_counter_param #(.WIDTH(4), .MODULUS(10), .ONE_SHOT(1)) dut_os (
    .clk(clk), .rst_n(rst_n), .clr_n(clr_n), .load_n(load_n), .d(d),
    .enp(enp), .ent(ent), .dir(dir), .oe(oe), .q(q1), .tc(tc1),
    .rco(rco1), .wrap(wrap1), .done(done1), .load_err(le1)
  );

  sync_counter_param #(.WIDTH(4), .MODULUS(16), .ONE_SHOT(0)) dut_lo (
    .clk(clk), .rst_n(rst_n), .clr_n(c_clr_n), .load_n(c_load_n),
    .d(c_dlo), .enp(c_en), .ent(c_en), .dir(c_dir), .oe(c_oe),
    .q(lo_q), .tc(lo_tc), .rco(lo_rco), .wrap(lo_wrap),
    .done(lo_done), .load_err(lo_le)
  );

  sync_counter_param #(.WIDTH(4), .MODULUS(16), .ONE_SHOT(0)) dut_hi (
    .clk(clk), .rst_n(rst_n), .clr_n(c_clr_n), .load_n(c_load_n),
    .d(c_dhi), .enp(c_en), .ent(lo_rco), .dir(c_dir), .oe(c_oe),
    .q(hi_q), .tc(hi_tc), .rco(hi_rco), .wrap(hi_wrap),
    .done(hi_done), .load_err(hi_le)
  );

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k]  = 0;
      m_wrap[k] = 0;
      m_le[k]   = 0;
      m_done[k] = 0;
    end
    cv = 0;
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      m_wrap[k] = 0;
      m_le[k]   = 0;
      if (!clr_n) begin
        m_cnt[k]  = 0;
        m_done[k] = 0;
      end else if (!load_n) begin
        m_le[k]   = (d >= 10);
        m_cnt[k]  = (d >= 10) ? 9 : int'(d);
        m_done[k] = 0;
      end else if (enp && ent && !(k == 1 && m_done[k])) begin
        if (k == 1 && m_cnt[k] == (dir ? 9 : 0)) begin
          m_done[k] = 1;
        end else begin
          m_wrap[k] = dir ? (m_cnt[k] == 9) : (m_cnt[k] == 0);
          m_cnt[k]  = dir ? (m_cnt[k] + 1) % 10 : (m_cnt[k] + 9) % 10;
        end
      end
    end
    if (!c_clr_n) cv = 0;
    else if (!c_load_n) cv = {c_dhi, c_dlo};
    else if (c_en) cv = (cv + 1) % 256;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; clr_n = 1; load_n = 1; d = 0;
    enp = 0; ent = 0; dir = 1; oe = 1;
    c_clr_n = 1; c_load_n = 1; c_en = 0; c_dir = 1; c_oe = 1;
    c_dlo = 0; c_dhi = 0;
    model_reset();
    #2;
    total++;
    if ({q0, wrap0, le0, done1, tc0} !== 8'b0000_0000) begin
      bad++;
      $display("FAIL reset_state got q=%0d w=%b le=%b dn=%b tc=%b want 0",
               q0, wrap0, le0, done1, tc0);
    end
    #2 rst_n = 1;
    enp = 1; ent = 1;
    for (int i = 0; i < 7; i++) tick();
    total++;
    if (q0 !== 4'd7) begin
      bad++;
      $display("FAIL pre_reset_count got %0d want 7", q0);
    end
    #2 rst_n = 0;
    #1;
    model_reset();
    total++;
    if ({q0, q1, wrap0, done1, le0} !== 11'd0) begin
      bad++;
      $display("FAIL async_reset got q0=%0d q1=%0d w=%b dn=%b want 0",
               q0, q1, wrap0, done1);
    end
    rst_n = 1;
  endtask

  task automatic test_decade_wrap();
    clr_n = 0; load_n = 1; enp = 0; ent = 0; dir = 1; oe = 1;
    tick();
    clr_n = 1; enp = 1; ent = 1;
    for (int i = 0; i < 12; i++) begin
      total++;
      if (tc0 !== (m_cnt[0] == 9)) begin
        bad++;
        $display("FAIL wrap_tc got %b want %b at q=%0d",
                 tc0, (m_cnt[0] == 9), m_cnt[0]);
      end
      tick();
      total++;
      if (q0 !== 4'(m_cnt[0]) || wrap0 !== m_wrap[0]) begin
        bad++;
        $display("FAIL wrap_cnt got q=%0d w=%b want q=%0d w=%b",
                 q0, wrap0, m_cnt[0], m_wrap[0]);
      end
    end
  endtask

  task automatic test_down_clamp();
    load_n = 0; d = 4'd13; enp = 0;
    tick();
    total++;
    if (q0 !== 4'd9 || le0 !== 1'b1) begin
      bad++;
      $display("FAIL clamp_load got q=%0d le=%b want q=9 le=1", q0, le0);
    end
    load_n = 1; dir = 0; enp = 1; ent = 1;
    tick();
    total++;
    if (le0 !== 1'b0 || q0 !== 4'(m_cnt[0])) begin
      bad++;
      $display("FAIL clamp_pulse got q=%0d le=%b want q=%0d le=0",
               q0, le0, m_cnt[0]);
    end
    for (int i = 0; i < 11; i++) begin
      total++;
      if (tc0 !== (m_cnt[0] == 0) || rco0 !== (m_cnt[0] == 0)) begin
        bad++;
        $display("FAIL down_tc got tc=%b rco=%b at q=%0d",
                 tc0, rco0, m_cnt[0]);
      end
      tick();
      total++;
      if (q0 !== 4'(m_cnt[0]) || wrap0 !== m_wrap[0]) begin
        bad++;
        $display("FAIL down_cnt got q=%0d w=%b want q=%0d w=%b",
                 q0, wrap0, m_cnt[0], m_wrap[0]);
      end
    end
  endtask

  task automatic test_priority();
    clr_n = 0; load_n = 0; d = 4'd5; dir = 1; enp = 1; ent = 1;
    tick();
    total++;
    if (q0 !== 4'd0 || le0 !== 1'b0) begin
      bad++;
      $display("FAIL clr_over_load got q=%0d le=%b want 0 0", q0, le0);
    end
    clr_n = 1;
    tick();
    total++;
    if (q0 !== 4'd5) begin
      bad++;
      $display("FAIL load_over_step got %0d want 5", q0);
    end
    load_n = 1;
  endtask

  task automatic test_one_shot();
    load_n = 0; d = 4'd7; dir = 1; enp = 1; ent = 1;
    tick();
    load_n = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (q1 !== 4'(m_cnt[1]) || done1 !== m_done[1] ||
          wrap1 !== 1'b0 || done0 !== 1'b0) begin
        bad++;
        $display("FAIL one_shot got q=%0d dn=%b w=%b want q=%0d dn=%b w=0",
                 q1, done1, wrap1, m_cnt[1], m_done[1]);
      end
    end
    load_n = 0; d = 4'd2;
    tick();
    total++;
    if (done1 !== 1'b0 || q1 !== 4'd2) begin
      bad++;
      $display("FAIL os_reload got q=%0d dn=%b want q=2 dn=0", q1, done1);
    end
    load_n = 1;
    tick();
    total++;
    if (q1 !== 4'd3) begin
      bad++;
      $display("FAIL os_resume got %0d want 3", q1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        #2 rst_n = 0;
        #1;
        model_reset();
        total++;
        if ({q0, q1, wrap0, wrap1, le0, le1, done1} !== 13'd0) begin
          bad++;
          $display("FAIL rnd_reset got q0=%0d q1=%0d want 0", q0, q1);
        end
        rst_n = 1;
      end
      clr_n  = ($urandom_range(0, 15) != 0);
      load_n = ($urandom_range(0, 7) != 0);
      d      = 4'($urandom);
      enp    = ($urandom_range(0, 5) != 0);
      ent    = ($urandom_range(0, 5) != 0);
      oe     = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) dir = ~dir;
      #1;
      for (int k = 0; k < 2; k++) begin
        logic [3:0] eq;
        logic       etc;
        eq  = oe ? 4'(m_cnt[k]) : 4'd0;
        etc = ent && (m_cnt[k] == (dir ? 9 : 0));
        total++;
        if ((k == 0 ? {q0, tc0, rco0} : {q1, tc1, rco1}) !==
            {eq, etc, etc & enp}) begin
          bad++;
          $display("FAIL rnd_comb%0d got %b want %b", k,
                   (k == 0 ? {q0, tc0, rco0} : {q1, tc1, rco1}),
                   {eq, etc, etc & enp});
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        logic [3:0] eq;
        eq = oe ? 4'(m_cnt[k]) : 4'd0;
        total++;
        if ((k == 0 ? {q0, wrap0, le0, done0} : {q1, wrap1, le1, done1})
            !== {eq, m_wrap[k], m_le[k], (k == 1) && m_done[k]}) begin
          bad++;
          $display("FAIL rnd_reg%0d got %b want %b", k,
                   (k == 0 ? {q0, wrap0, le0, done0}
                           : {q1, wrap1, le1, done1}),
                   {eq, m_wrap[k], m_le[k], (k == 1) && m_done[k]});
        end
      end
    end
    oe = 1; clr_n = 1; load_n = 1;
  endtask

  task automatic test_cascade();
    enp = 0; ent = 0;
    c_load_n = 0; c_dlo = 4'hF; c_dhi = 4'h0; c_en = 1; c_oe = 1;
    tick();
    c_load_n = 1;
    #1;
    total++;
    if (lo_rco !== 1'b1 || {hi_q, lo_q} !== 8'h0F) begin
      bad++;
      $display("FAIL casc_load got %h rco=%b want 0f rco=1",
               {hi_q, lo_q}, lo_rco);
    end
    tick();
    total++;
    if ({hi_q, lo_q} !== 8'h10) begin
      bad++;
      $display("FAIL casc_carry got %h want 10", {hi_q, lo_q});
    end
    c_oe = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if ({hi_q, lo_q} !== 8'h00) begin
        bad++;
        $display("FAIL casc_oe got %h want 00", {hi_q, lo_q});
      end
    end
    c_oe = 1;
    #1;
    total++;
    if ({hi_q, lo_q} !== 8'(cv)) begin
      bad++;
      $display("FAIL casc_hidden got %h want %h", {hi_q, lo_q}, 8'(cv));
    end
    c_en = 0;
  endtask

  initial begin
    test_reset();
    test_decade_wrap();
    test_down_clamp();
    test_priority();
    test_one_shot();
    test_random();
    test_cascade();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
